// File: rtl/rcc_domain_wkup_seq_pkg.sv
// Shared types for the RCC domain wakeup sequencer: per-domain FSM states,
// counter widths and the state-to-output decode.
package rcc_pkg;

   localparam int NUM_DOM    = 3;
   localparam int HOLD_CNT_W = 8;
   localparam int TMO_CNT_W  = 12;

   typedef enum logic [2:0] {
      ST_OFF,
      ST_WAIT_CLK,
      ST_RST_HOLD,
      ST_RUN,
      ST_PD
   } rcc_dom_state_t;

   typedef struct packed {
      logic clk_en;
      logic rst_n;
      logic rdy;
   } rcc_dom_out_t;

   // Output pattern of a state; registered together with the state itself.
   function automatic rcc_dom_out_t dom_out(input rcc_dom_state_t st);
      rcc_dom_out_t o;
      o = '0;
      case (st)
         ST_RST_HOLD, ST_PD: o.clk_en = 1'b1;
         ST_RUN:             o = '{clk_en: 1'b1, rst_n: 1'b1, rdy: 1'b1};
         default:            o = '0;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/rcc_domain_wkup_seq_if.sv
// Power-controller side signals of the wakeup sequencer: wakeup/power-down
// requests in, per-domain clock/reset/status out.
interface rcc_domain_wkup_seq_if;

   logic pwr_d1_wkup, pwr_d2_wkup, pwr_d3_wkup;
   logic hsi_rdy;
   logic d1_pd_req, d2_pd_req, d3_pd_req;
   logic err_clr;
   logic d1_clk_en, d2_clk_en, d3_clk_en;
   logic d1_rst_n, d2_rst_n, d3_rst_n;
   logic d1_rdy, d2_rdy, d3_rdy;
   logic d1_tmo_err, d2_tmo_err, d3_tmo_err;

   modport master (
      output pwr_d1_wkup, pwr_d2_wkup, pwr_d3_wkup, hsi_rdy,
             d1_pd_req, d2_pd_req, d3_pd_req, err_clr,
      input  d1_clk_en, d2_clk_en, d3_clk_en, d1_rst_n, d2_rst_n, d3_rst_n,
             d1_rdy, d2_rdy, d3_rdy, d1_tmo_err, d2_tmo_err, d3_tmo_err
   );

   modport slave (
      input  pwr_d1_wkup, pwr_d2_wkup, pwr_d3_wkup, hsi_rdy,
             d1_pd_req, d2_pd_req, d3_pd_req, err_clr,
      output d1_clk_en, d2_clk_en, d3_clk_en, d1_rst_n, d2_rst_n, d3_rst_n,
             d1_rdy, d2_rdy, d3_rdy, d1_tmo_err, d2_tmo_err, d3_tmo_err
   );

endinterface

// File: rtl/rcc_domain_wkup_seq_dom_seq.sv
// Per-domain power sequencer: OFF -> WAIT_CLK -> RST_HOLD -> RUN -> PD -> OFF.
// Outputs are registered alongside the state; tmo_evt flags a timeout this cycle.
module rcc_dom_seq import rcc_pkg::*; #(
   parameter int RST_HOLD_CYC = 16,
   parameter int CLK_TMO_CYC  = 1023
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wkup,
   input  logic         pd_req,
   input  logic         hsi_rdy,
   input  logic         gate,
   output rcc_dom_out_t dout,
   output logic         tmo_evt
);

   localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(RST_HOLD_CYC - 1);
   localparam logic [TMO_CNT_W-1:0]  TMO_LAST  = TMO_CNT_W'(CLK_TMO_CYC - 1);

   rcc_dom_state_t        state;
   logic [HOLD_CNT_W-1:0] hold_cnt;
   logic [TMO_CNT_W-1:0]  tmo_cnt;
   logic                  adv;

   // Abort beats advance beats timeout, so an abort never records an error.
   assign adv     = hsi_rdy & gate;
   assign tmo_evt = (state == ST_WAIT_CLK) & ~pd_req & ~adv & (tmo_cnt == TMO_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_OFF;
         dout     <= '0;
         hold_cnt <= '0;
         tmo_cnt  <= '0;
      end else begin
         // Counters only advance while staying put, so every entry sees zero.
         hold_cnt <= '0;
         tmo_cnt  <= '0;
         case (state)
            ST_OFF:
               if (wkup && !pd_req) begin
                  state <= ST_WAIT_CLK;
                  dout  <= dom_out(ST_WAIT_CLK);
               end
            ST_WAIT_CLK:
               if (pd_req) begin
                  state <= ST_OFF;
                  dout  <= dom_out(ST_OFF);
               end else if (adv) begin
                  state <= ST_RST_HOLD;
                  dout  <= dom_out(ST_RST_HOLD);
               end else if (tmo_evt) begin
                  state <= ST_OFF;
                  dout  <= dom_out(ST_OFF);
               end else begin
                  tmo_cnt <= (tmo_cnt == '1) ? tmo_cnt : tmo_cnt + 1'b1;
               end
            ST_RST_HOLD:
               if (pd_req) begin
                  state <= ST_OFF;
                  dout  <= dom_out(ST_OFF);
               end else if (!gate) begin
                  state <= ST_PD;
                  dout  <= dom_out(ST_PD);
               end else if (hold_cnt == HOLD_LAST) begin
                  state <= ST_RUN;
                  dout  <= dom_out(ST_RUN);
               end else begin
                  hold_cnt <= (hold_cnt == '1) ? hold_cnt : hold_cnt + 1'b1;
               end
            ST_RUN:
               if (pd_req || !wkup || !gate) begin
                  state <= ST_PD;
                  dout  <= dom_out(ST_PD);
               end
            ST_PD: begin
               state <= ST_OFF;
               dout  <= dom_out(ST_OFF);
            end
            default: begin
               state <= ST_OFF;
               dout  <= dom_out(ST_OFF);
            end
         endcase
      end
   end

endmodule

// File: rtl/rcc_domain_wkup_seq.sv
// RCC domain wakeup sequencer top: wakeup synchronizers, D3 gating of D1/D2,
// three per-domain sequencers and the sticky clock-wait timeout flags.
module rcc_domain_wkup_seq import rcc_pkg::*; #(
   parameter int RST_HOLD_CYC = 16,
   parameter int CLK_TMO_CYC  = 1023
) (
   input  logic                  rcc_clk,
   input  logic                  rcc_rst,
   rcc_domain_wkup_seq_if.slave  bus
);

   logic [NUM_DOM-1:0]         wkup_raw, wkup_s0, wkup_s1;
   logic [NUM_DOM-1:0]         pd_req, gate, tmo_evt, tmo_err;
   rcc_dom_out_t [NUM_DOM-1:0] dout;

   assign wkup_raw = {bus.pwr_d3_wkup, bus.pwr_d2_wkup, bus.pwr_d1_wkup};
   assign pd_req   = {bus.d3_pd_req, bus.d2_pd_req, bus.d1_pd_req};

   // D3 hosts the shared infrastructure; D1/D2 may only hold or run while it is up.
   assign gate = {1'b1, dout[2].rdy, dout[2].rdy};

   always_ff @(posedge rcc_clk) begin
      if (rcc_rst) begin
         wkup_s0 <= '0;
         wkup_s1 <= '0;
         tmo_err <= '0;
      end else begin
         wkup_s0 <= wkup_raw;
         wkup_s1 <= wkup_s0;
         tmo_err <= (tmo_err & ~{NUM_DOM{bus.err_clr}}) | tmo_evt;
      end
   end

   for (genvar i = 0; i < NUM_DOM; i++) begin : g_dom
      rcc_dom_seq #(
         .RST_HOLD_CYC (RST_HOLD_CYC),
         .CLK_TMO_CYC  (CLK_TMO_CYC)
      ) u_seq (
         .clk     (rcc_clk),
         .rst     (rcc_rst),
         .wkup    (wkup_s1[i]),
         .pd_req  (pd_req[i]),
         .hsi_rdy (bus.hsi_rdy),
         .gate    (gate[i]),
         .dout    (dout[i]),
         .tmo_evt (tmo_evt[i])
      );
   end

   assign bus.d1_clk_en  = dout[0].clk_en;
   assign bus.d2_clk_en  = dout[1].clk_en;
   assign bus.d3_clk_en  = dout[2].clk_en;
   assign bus.d1_rst_n   = dout[0].rst_n;
   assign bus.d2_rst_n   = dout[1].rst_n;
   assign bus.d3_rst_n   = dout[2].rst_n;
   assign bus.d1_rdy     = dout[0].rdy;
   assign bus.d2_rdy     = dout[1].rdy;
   assign bus.d3_rdy     = dout[2].rdy;
   assign bus.d1_tmo_err = tmo_err[0];
   assign bus.d2_tmo_err = tmo_err[1];
   assign bus.d3_tmo_err = tmo_err[2];

endmodule

// File: tb/tb_rcc_domain_wkup_seq.sv
// Directed bench for rcc_domain_wkup_seq: a vector table for the main
// wakeup / power-down / timeout flow plus hand sequences for the corner cases.
module tb_rcc_domain_wkup_seq;

   logic rcc_clk = 1'b0;
   logic rcc_rst;
   always #5 rcc_clk = ~rcc_clk;

   rcc_domain_wkup_seq_if bus();

   rcc_domain_wkup_seq #(.RST_HOLD_CYC(16), .CLK_TMO_CYC(1023)) dut (
      .rcc_clk (rcc_clk),
      .rcc_rst (rcc_rst),
      .bus     (bus)
   );

   int n_chk = 0;
   int n_err = 0;

   // Inputs and expected outputs after ncyc clocks.
   // exp = {clk_en d3..d1, rst_n d3..d1, rdy d3..d1, tmo_err d3..d1}
   typedef struct {
      logic        rst;
      logic [2:0]  wkup;
      logic [2:0]  pd;
      logic        hsi;
      logic        clr;
      int          ncyc;
      logic [11:0] exp;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic rst, input logic [2:0] wkup, input logic [2:0] pd,
                               input logic hsi, input logic clr, input int ncyc,
                               input logic [11:0] exp);
      vec_t v;
      v.rst = rst; v.wkup = wkup; v.pd = pd; v.hsi = hsi; v.clr = clr;
      v.ncyc = ncyc; v.exp = exp;
      return v;
   endfunction

   function automatic logic [11:0] outs();
      return {bus.d3_clk_en, bus.d2_clk_en, bus.d1_clk_en,
              bus.d3_rst_n, bus.d2_rst_n, bus.d1_rst_n,
              bus.d3_rdy, bus.d2_rdy, bus.d1_rdy,
              bus.d3_tmo_err, bus.d2_tmo_err, bus.d1_tmo_err};
   endfunction

   task automatic drive(input logic rst, input logic [2:0] wkup, input logic [2:0] pd,
                        input logic hsi, input logic clr);
      rcc_rst         = rst;
      bus.pwr_d3_wkup = wkup[2];
      bus.pwr_d2_wkup = wkup[1];
      bus.pwr_d1_wkup = wkup[0];
      bus.d3_pd_req   = pd[2];
      bus.d2_pd_req   = pd[1];
      bus.d1_pd_req   = pd[0];
      bus.hsi_rdy     = hsi;
      bus.err_clr     = clr;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge rcc_clk);
         @(negedge rcc_clk);
      end
   endtask

   task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b, expected %b", nm, act, exp);
      end
   endtask

   initial begin
      // Reset with wkup high, D3 bring-up, D1 bring-up gated by D3, D2 held off by pd_req.
      tbl.push_back(mk(1, 3'b111, 3'b000, 1, 0,    2, 12'b000_000_000_000));
      tbl.push_back(mk(0, 3'b100, 3'b000, 1, 0,    1, 12'b000_000_000_000));
      tbl.push_back(mk(0, 3'b100, 3'b000, 1, 0,    1, 12'b000_000_000_000));
      tbl.push_back(mk(0, 3'b100, 3'b000, 1, 0,    1, 12'b000_000_000_000));
      tbl.push_back(mk(0, 3'b100, 3'b000, 1, 0,    1, 12'b100_000_000_000));
      tbl.push_back(mk(0, 3'b100, 3'b000, 1, 0,   15, 12'b100_000_000_000));
      tbl.push_back(mk(0, 3'b100, 3'b000, 1, 0,    1, 12'b100_100_100_000));
      tbl.push_back(mk(0, 3'b101, 3'b000, 1, 0,    3, 12'b100_100_100_000));
      tbl.push_back(mk(0, 3'b101, 3'b000, 1, 0,    1, 12'b101_100_100_000));
      tbl.push_back(mk(0, 3'b101, 3'b000, 1, 0,   15, 12'b101_100_100_000));
      tbl.push_back(mk(0, 3'b101, 3'b000, 1, 0,    1, 12'b101_101_101_000));
      tbl.push_back(mk(0, 3'b111, 3'b010, 1, 0,    4, 12'b101_101_101_000));
      // Drop D3 wakeup: D3 PD, then D1 PD one cycle later, reset before gating.
      tbl.push_back(mk(0, 3'b001, 3'b010, 1, 0,    2, 12'b101_101_101_000));
      tbl.push_back(mk(0, 3'b001, 3'b010, 1, 0,    1, 12'b101_001_001_000));
      tbl.push_back(mk(0, 3'b001, 3'b010, 1, 0,    1, 12'b001_000_000_000));
      tbl.push_back(mk(0, 3'b001, 3'b010, 1, 0,    1, 12'b000_000_000_000));
      // D1 waits for D3 that never comes: timeout after 1023 cycles in WAIT_CLK.
      tbl.push_back(mk(0, 3'b001, 3'b010, 1, 0,    1, 12'b000_000_000_000));
      tbl.push_back(mk(0, 3'b000, 3'b010, 1, 0, 1022, 12'b000_000_000_000));
      tbl.push_back(mk(0, 3'b000, 3'b010, 1, 0,    1, 12'b000_000_000_001));
      tbl.push_back(mk(0, 3'b000, 3'b010, 1, 0,    5, 12'b000_000_000_001));
      tbl.push_back(mk(0, 3'b000, 3'b010, 1, 1,    1, 12'b000_000_000_000));
      tbl.push_back(mk(0, 3'b000, 3'b010, 1, 0,    1, 12'b000_000_000_000));

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].wkup, tbl[i].pd, tbl[i].hsi, tbl[i].clr);
         tick(tbl[i].ncyc);
         chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
      end

      // pd_req while D3 is in RST_HOLD at count 7: straight to OFF, no error.
      drive(0, 3'b100, 3'b000, 1, 0);
      tick(4);  chk("pdh_enter", outs(), 12'b100_000_000_000);
      tick(7);  chk("pdh_cnt7",  outs(), 12'b100_000_000_000);
      drive(0, 3'b100, 3'b100, 1, 0);
      tick(1);  chk("pdh_abort", outs(), 12'b000_000_000_000);
      tick(3);  chk("pdh_stay",  outs(), 12'b000_000_000_000);
      drive(0, 3'b000, 3'b100, 1, 0);
      tick(3);
      drive(0, 3'b000, 3'b000, 1, 0);
      tick(2);  chk("pdh_idle",  outs(), 12'b000_000_000_000);

      // D3 timeout coinciding with err_clr: set wins, flag is sticky.
      drive(0, 3'b100, 3'b000, 0, 0);
      tick(3);
      drive(0, 3'b000, 3'b000, 0, 0);
      tick(1022); chk("tmo_pre",      outs(), 12'b000_000_000_000);
      drive(0, 3'b000, 3'b000, 0, 1);
      tick(1);    chk("tmo_set_wins", outs(), 12'b000_000_000_100);
      drive(0, 3'b000, 3'b000, 0, 0);
      tick(3);    chk("tmo_sticky",   outs(), 12'b000_000_000_100);
      drive(0, 3'b000, 3'b000, 0, 1);
      tick(1);    chk("tmo_clr",      outs(), 12'b000_000_000_000);

      // hsi_rdy arrives on the timeout cycle: advance wins.
      drive(0, 3'b100, 3'b000, 0, 0);
      tick(3);
      tick(1022); chk("tie_pre", outs(), 12'b000_000_000_000);
      drive(0, 3'b100, 3'b000, 1, 0);
      tick(1);    chk("tie_adv", outs(), 12'b100_000_000_000);
      tick(16);   chk("tie_run", outs(), 12'b100_100_100_000);

      // All domains running, then a reset pulse with wakeups held high.
      drive(0, 3'b111, 3'b000, 1, 0);
      tick(4);  chk("all_hold",      outs(), 12'b111_100_100_000);
      tick(16); chk("all_run",       outs(), 12'b111_111_111_000);
      drive(1, 3'b111, 3'b000, 1, 0);
      tick(1);  chk("rst_pulse",     outs(), 12'b000_000_000_000);
      drive(0, 3'b111, 3'b000, 1, 0);
      tick(3);  chk("rst_sync",      outs(), 12'b000_000_000_000);
      tick(1);  chk("re_d3_hold",    outs(), 12'b100_000_000_000);
      tick(15); chk("re_d3_hold_end",outs(), 12'b100_000_000_000);
      tick(1);  chk("re_d3_run",     outs(), 12'b100_100_100_000);
      tick(1);  chk("re_d12_hold",   outs(), 12'b111_100_100_000);
      tick(16); chk("re_all_run",    outs(), 12'b111_111_111_000);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
